// File: rtl/cache_types.sv
// Types and constants shared by the cache datapath blocks.
package cache_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } adaptor_state_t;

    localparam int BURST_BEATS = 256 / 64;

endpackage

// File: rtl/cacheline_adaptor.sv
// Converts 256-bit cache line fills and writebacks into four-beat 64-bit
// memory bursts. Every memory-side output comes from a register.
module cacheline_adaptor
    import cache_types::*;
#(
    parameter int s_line   = 256,
    parameter int s_burst  = 64,
    parameter int s_addr   = 32,
    parameter int s_offset = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [s_line-1:0]   line_i,
    output logic [s_line-1:0]   line_o,
    input  logic [s_addr-1:0]   address_i,
    input  logic                read_i,
    input  logic                write_i,
    output logic                resp_o,
    input  logic [s_burst-1:0]  burst_i,
    output logic [s_burst-1:0]  burst_o,
    output logic [s_addr-1:0]   address_o,
    output logic                read_o,
    output logic                write_o,
    input  logic                resp_i
);

    localparam logic [1:0] LAST_BEAT = 2'(BURST_BEATS - 1);

    adaptor_state_t     state;
    logic [1:0]         k;
    logic [s_line-1:0]  line_q;
    logic [s_line-1:0]  fill_line;

    // The line as it will look once the current read beat is merged in.
    always_comb begin
        fill_line = line_q;
        fill_line[k*s_burst +: s_burst] = burst_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= 2'd0;
            line_q    <= '0;
            line_o    <= '0;
            burst_o   <= '0;
            address_o <= '0;
            read_o    <= 1'b0;
            write_o   <= 1'b0;
            resp_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    k <= 2'd0;
                    // Writeback takes priority; a pending fill is re-presented later.
                    if (write_i) begin
                        state     <= WR;
                        address_o <= {address_i[s_addr-1:s_offset], {s_offset{1'b0}}};
                        line_q    <= line_i;
                        burst_o   <= line_i[s_burst-1:0];
                        write_o   <= 1'b1;
                    end else if (read_i) begin
                        state     <= RD;
                        address_o <= {address_i[s_addr-1:s_offset], {s_offset{1'b0}}};
                        read_o    <= 1'b1;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        line_q <= fill_line;
                        k      <= k + 2'd1;
                        if (k == LAST_BEAT) begin
                            line_o <= fill_line;
                            read_o <= 1'b0;
                            resp_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WR: begin
                    // line_q shifts down so the next beat is always in its low slice.
                    if (resp_i) begin
                        line_q  <= line_q >> s_burst;
                        burst_o <= line_q[2*s_burst-1:s_burst];
                        k       <= k + 2'd1;
                        if (k == LAST_BEAT) begin
                            write_o <= 1'b0;
                            resp_o  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_o <= 1'b0;
                    k      <= 2'd0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: fills, writebacks, stalls,
// request priority, input stability and mid-burst reset.
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int passed = 0;
    int total  = 0;

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D2 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] D3 = 64'h0BAD_F00D_1234_ABCD;
    localparam logic [63:0] A0 = 64'hA0A0_0000_0000_00A0;
    localparam logic [63:0] A1 = 64'hA1A1_0000_0000_00A1;
    localparam logic [63:0] A2 = 64'hA2A2_0000_0000_00A2;
    localparam logic [63:0] A3 = 64'hA3A3_0000_0000_00A3;

    logic [63:0] stall_beats [4];
    logic        stall_pat   [7];

    initial begin
        int beat;
        stall_beats = '{A0, A1, A2, A3};
        stall_pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        tick();
        check("rst_read_o", 256'(read_o), 256'd0);
        check("rst_write_o", 256'(write_o), 256'd0);
        check("rst_resp_o", 256'(resp_o), 256'd0);
        check("rst_line_o", line_o, 256'd0);
        rst = 1'b1;
        tick();

        // Read fill, back-to-back beats.
        read_i = 1'b1; address_i = 32'h1234_567F;
        tick();
        read_i = 1'b0;
        check("fill_read_o", 256'(read_o), 256'd1);
        check("fill_addr_o", 256'(address_o), 256'h1234_5660);
        check("fill_write_o", 256'(write_o), 256'd0);
        resp_i = 1'b1; burst_i = B1; tick();
        check("fill_resp_early", 256'(resp_o), 256'd0);
        burst_i = B2; tick();
        burst_i = B3; tick();
        burst_i = B4; tick();
        resp_i = 1'b0; burst_i = '0;
        check("fill_resp_o", 256'(resp_o), 256'd1);
        check("fill_read_drop", 256'(read_o), 256'd0);
        check("fill_line_o", line_o, {B4, B3, B2, B1});
        tick();
        check("fill_resp_pulse", 256'(resp_o), 256'd0);
        tick();

        // Writeback, with cache inputs disturbed mid-burst.
        write_i = 1'b1; line_i = {D3, D2, D1, D0}; address_i = 32'h8000_0044;
        tick();
        write_i = 1'b0; line_i = {4{64'hFFFF_FFFF_FFFF_FFFF}}; address_i = 32'h0000_1F1F;
        check("wb_write_o", 256'(write_o), 256'd1);
        check("wb_addr_o", 256'(address_o), 256'h8000_0040);
        check("wb_beat0", 256'(burst_o), 256'(D0));
        resp_i = 1'b1; tick();
        check("wb_beat1", 256'(burst_o), 256'(D1));
        check("wb_addr_hold", 256'(address_o), 256'h8000_0040);
        tick();
        check("wb_beat2", 256'(burst_o), 256'(D2));
        tick();
        check("wb_beat3", 256'(burst_o), 256'(D3));
        check("wb_write_hold", 256'(write_o), 256'd1);
        tick();
        resp_i = 1'b0;
        check("wb_write_drop", 256'(write_o), 256'd0);
        check("wb_resp_o", 256'(resp_o), 256'd1);
        check("wb_line_o_kept", line_o, {B4, B3, B2, B1});
        tick();
        check("wb_resp_pulse", 256'(resp_o), 256'd0);

        // Stalled read: resp_i pattern 1,0,0,1,1,0,1.
        read_i = 1'b1; address_i = 32'h0000_ABFF;
        tick();
        read_i = 1'b0;
        beat = 0;
        for (int i = 0; i < 7; i++) begin
            resp_i  = stall_pat[i];
            burst_i = stall_pat[i] ? stall_beats[beat] : 64'hBAD0_BAD0_BAD0_BAD0;
            if (stall_pat[i]) beat++;
            check("stall_read_o", 256'(read_o), 256'd1);
            check("stall_resp_o", 256'(resp_o), 256'd0);
            tick();
        end
        resp_i = 1'b0;
        check("stall_resp_final", 256'(resp_o), 256'd1);
        check("stall_line_o", line_o, {A3, A2, A1, A0});
        check("stall_addr_o", 256'(address_o), 256'h0000_ABE0);
        tick();

        // Simultaneous requests: write first, then the held read.
        read_i = 1'b1; write_i = 1'b1; line_i = {D0, D1, D2, D3}; address_i = 32'h0000_0100;
        tick();
        write_i = 1'b0;
        check("prio_write_o", 256'(write_o), 256'd1);
        check("prio_read_o", 256'(read_o), 256'd0);
        check("prio_beat0", 256'(burst_o), 256'(D3));
        resp_i = 1'b1;
        tick(); tick(); tick(); tick();
        resp_i = 1'b0;
        check("prio_wr_resp", 256'(resp_o), 256'd1);
        tick();
        check("prio_idle_read_o", 256'(read_o), 256'd0);
        tick();
        read_i = 1'b0;
        check("prio_read_start", 256'(read_o), 256'd1);
        resp_i = 1'b1;
        burst_i = B4; tick();
        burst_i = B3; tick();
        burst_i = B2; tick();
        burst_i = B1; tick();
        resp_i = 1'b0;
        check("prio_rd_resp", 256'(resp_o), 256'd1);
        check("prio_line_o", line_o, {B1, B2, B3, B4});
        tick();

        // Reset after two read beats abandons the burst.
        read_i = 1'b1; address_i = 32'h0000_2020;
        tick();
        read_i = 1'b0;
        resp_i = 1'b1; burst_i = B1; tick();
        burst_i = B2; tick();
        resp_i = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("abort_read_o", 256'(read_o), 256'd0);
        check("abort_addr_o", 256'(address_o), 256'd0);
        check("abort_line_o", line_o, 256'd0);
        check("abort_resp_o", 256'(resp_o), 256'd0);
        tick();
        rst = 1'b1;
        tick();
        check("abort_no_resp", 256'(resp_o), 256'd0);
        read_i = 1'b1; address_i = 32'h0000_3033;
        tick();
        read_i = 1'b0;
        check("fresh_read_o", 256'(read_o), 256'd1);
        check("fresh_addr_o", 256'(address_o), 256'h0000_3020);
        resp_i = 1'b1;
        burst_i = A3; tick();
        burst_i = A2; tick();
        burst_i = A1; tick();
        burst_i = A0; tick();
        resp_i = 1'b0;
        check("fresh_resp_o", 256'(resp_o), 256'd1);
        check("fresh_line_o", line_o, {A0, A1, A2, A3});
        tick();
        check("fresh_resp_pulse", 256'(resp_o), 256'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
